// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  // System clocks per line bit (integer division).
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised output).
module sync_2ff #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with start-glitch rejection and stop-bit framing check.
// Ports: clk, rst (async active-low), rx (raw serial line),
//        data (last good byte), valid (1-cycle strobe on new data),
//        frame_err (1-cycle strobe on bad stop bit), busy (FSM not idle).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  // Mid-bit sampling needs at least a few clocks per bit.
  generate
    if (CPB < 4) begin : g_bad_cpb
      $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (rx),
    .q     (rx_s)
  );

  uart_rx_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  busy_q, busy_d;

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          // Start bit must still be low at its midpoint, else it was a glitch.
          if (!rx_s) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          // Return at mid stop bit so a back-to-back start edge is not missed.
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx with a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned CPB = 10;
  localparam int LAT = 2 + 1 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (100_000),
    .DATA_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         kind;   // 0 = valid, 1 = frame_err
    logic [7:0] d;
    int         cyc;
  } ev_t;

  ev_t obs[$];
  ev_t exq[$];
  int  exp_rd = 0;
  int  ncyc = 0;
  bit  both_seen = 1'b0;
  logic [7:0] last_good = 8'h00;

  int n_chk = 0;
  int n_pass = 0;

  // Record every strobe with the negedge count at which it was seen.
  always @(negedge clk) begin
    ncyc++;
    if (valid === 1'b1 || frame_err === 1'b1) begin
      obs.push_back('{kind: frame_err, d: data, cyc: ncyc});
      if (valid === 1'b1 && frame_err === 1'b1) both_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, o, e);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  // Drive one 8N1 frame and log what the receiver should report for it.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    exq.push_back('{kind: !stop_ok, d: (stop_ok ? b : last_good), cyc: ncyc});
    if (stop_ok) last_good = b;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
  endtask

  task automatic check_events(input string tag);
    int lat;
    chk({tag, "_count"}, 32'(obs.size()), 32'(exq.size()));
    for (int i = exp_rd; i < exq.size(); i++) begin
      if (i < obs.size()) begin
        lat = obs[i].cyc - exq[i].cyc - 1;
        chk({tag, "_kind"}, 32'(obs[i].kind), 32'(exq[i].kind));
        chk({tag, "_data"}, 32'(obs[i].d), 32'(exq[i].d));
        chk({tag, "_latency_in_window"}, 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'(1));
      end
    end
    exp_rd = exq.size();
  endtask

  initial begin
    int k;
    logic [7:0] b;
    bit ok;

    // Reset state
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_ferr", 32'(frame_err), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_data", 32'(data), 32'(0));
    @(posedge clk);
    rst = 1'b1;
    idle(50);
    chk("idle_busy", 32'(busy), 32'(0));
    check_events("idle");

    // Single frame
    send_frame(8'hA5, 1'b1);
    idle(20);
    check_events("single");
    chk("single_data_out", 32'(data), 32'hA5);

    // Back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check_events("b2b");

    // Start glitch
    rx = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    @(negedge clk);
    chk("glitch_busy_seen", 32'(busy), 32'(1));
    k = 0;
    while (busy !== 1'b0 && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("glitch_busy_cleared", 32'(busy), 32'(0));
    @(posedge clk);
    idle(10);
    check_events("glitch");
    send_frame(8'h5A, 1'b1);
    idle(20);
    check_events("after_glitch");

    // Framing error
    send_frame(8'h81, 1'b0);
    idle(30);
    check_events("frame_err");
    chk("ferr_data_held", 32'(data), 32'h5A);

    // Reset mid-frame during bit 4 of 0x77
    b = 8'h77;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = b[4];
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midframe_busy", 32'(busy), 32'(1));
    rst = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_data", 32'(data), 32'(0));
    chk("async_rst_valid", 32'(valid), 32'(0));
    last_good = 8'h00;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b1;
    idle(30);
    check_events("rst_mid");
    send_frame(8'h12, 1'b1);
    idle(20);
    check_events("after_rst");
    chk("after_rst_data_out", 32'(data), 32'h12);

    // Randomized frames with random stop-bit errors and gaps
    for (int n = 0; n < 12; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(3) != 0);
      send_frame(b, ok);
      idle(ok ? int'($urandom_range(0, 25)) : int'($urandom_range(15, 30)));
    end
    idle(20);
    check_events("random");
    chk("random_data_out", 32'(data), 32'(last_good));
    chk("valid_ferr_exclusive", 32'(both_seen), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
